// File: rtl/bit_unpack_fifo.sv
`default_nettype none
// ============================================================================
// bit_unpack_fifo : WIDTH-bit word FIFO feeding a 2*WIDTH-bit buffer that
//                   serves variable-length LSB-first bit fields.
// Revision 1.0
// ============================================================================
module bit_unpack_fifo #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 16,
   parameter int AW     = 4,
   parameter int MAXREQ = 15,
   parameter int LW     = 4,
   parameter int BCW    = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pushin,
   input  logic [WIDTH-1:0]  datain,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic              overflow,
   input  logic              reqin,
   input  logic [LW-1:0]     reqlen,
   output logic              busy,
   output logic              pushout,
   output logic [LW-1:0]     lenout,
   output logic [MAXREQ-1:0] dataout,
   output logic [BCW-1:0]    bitcnt
);

   localparam int             CW       = AW + 1;
   localparam logic [LW-1:0]  C_MAXREQ = LW'(MAXREQ);
   localparam logic [BCW-1:0] C_WIDTH  = BCW'(WIDTH);
   localparam logic [CW-1:0]  C_DEPTH  = CW'(DEPTH);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [AW-1:0]      wptr_q, wptr_d;
   logic [AW-1:0]      rptr_q, rptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] buf_q, buf_d;
   logic [BCW-1:0]     bitcnt_q, bitcnt_d;
   state_t             state_q, state_d;
   logic [LW-1:0]      len_q, len_d;
   logic               overflow_q, overflow_d;
   logic               pushout_q, pushout_d;
   logic [LW-1:0]      lenout_q, lenout_d;
   logic [MAXREQ-1:0]  dataout_q, dataout_d;

   logic [LW-1:0]      req_len;
   logic [LW-1:0]      serve_len;
   logic [BCW-1:0]     rem;
   logic               do_push;
   logic               do_pop;
   logic [2*WIDTH-1:0] shifted;
   logic [2*WIDTH-1:0] head_ext;
   logic [MAXREQ-1:0]  field;

   assign fifo_full  = (count_q == C_DEPTH);
   assign fifo_empty = (count_q == '0);
   assign overflow   = overflow_q;
   assign busy       = (state_q == S_WAIT);
   assign pushout    = pushout_q;
   assign lenout     = lenout_q;
   assign dataout    = dataout_q;
   assign bitcnt     = bitcnt_q;

   // Request handling; serve_len is zero on edges that deliver nothing.
   always_comb begin
      req_len   = (reqlen > C_MAXREQ) ? C_MAXREQ : reqlen;
      serve_len = '0;
      state_d   = state_q;
      len_d     = len_q;
      case (state_q)
         S_IDLE: begin
            if (reqin && (reqlen != '0)) begin
               len_d = req_len;
               if (bitcnt_q >= BCW'(req_len)) begin
                  serve_len = req_len;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (bitcnt_q >= BCW'(len_q)) begin
               serve_len = len_q;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      field = '0;
      for (int i = 0; i < MAXREQ; i++) begin
         field[i] = buf_q[i] & (LW'(i) < serve_len);
      end
   end

   // Bits above bitcnt are always zero, so the refill word can simply be OR-ed in at rem.
   always_comb begin
      do_push  = pushin && !fifo_full;
      rem      = bitcnt_q - BCW'(serve_len);
      do_pop   = (rem <= C_WIDTH) && !fifo_empty;
      shifted  = buf_q >> serve_len;
      head_ext = {{WIDTH{1'b0}}, mem_q[rptr_q]} << rem;

      buf_d    = shifted;
      bitcnt_d = rem;
      rptr_d   = rptr_q;
      if (do_pop) begin
         buf_d    = shifted | head_ext;
         bitcnt_d = rem + C_WIDTH;
         rptr_d   = rptr_q + AW'(1);
      end

      wptr_d     = do_push ? (wptr_q + AW'(1)) : wptr_q;
      count_d    = count_q + CW'(do_push) - CW'(do_pop);
      overflow_d = overflow_q | (pushin & fifo_full);

      pushout_d  = (serve_len != '0);
      lenout_d   = lenout_q;
      dataout_d  = dataout_q;
      if (pushout_d) begin
         lenout_d  = serve_len;
         dataout_d = field;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wptr_q] <= datain;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         buf_q      <= '0;
         bitcnt_q   <= '0;
         state_q    <= S_IDLE;
         len_q      <= '0;
         overflow_q <= 1'b0;
         pushout_q  <= 1'b0;
         lenout_q   <= '0;
         dataout_q  <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         buf_q      <= buf_d;
         bitcnt_q   <= bitcnt_d;
         state_q    <= state_d;
         len_q      <= len_d;
         overflow_q <= overflow_d;
         pushout_q  <= pushout_d;
         lenout_q   <= lenout_d;
         dataout_q  <= dataout_d;
      end
   end

endmodule
`default_nettype wire
